ula_8bit: RTL and testbench
===========================

# ula_8bit

8-bit 74181-style arithmetic/logic unit (ULA) with registered outputs. It takes two operands, a 4-bit function select, a mode bit and a carry-in. It produces the result, carry-out, signed overflow, an all-ones (A=B) flag and group carry-lookahead propagate/generate signals. It is the datapath ALU slice; P/G allow cascading into a lookahead carry unit.

## Interface
Parameters: none; width fixed at 8.
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- a  in  8  operand A
- b  in  8  operand B
- s  in  4  function select S3..S0
- m  in  1  mode: 0 = arithmetic, 1 = logic
- c_in  in  1  carry-in, active-high, added to the arithmetic result
- f  out  8  result
- a_eq_b  out  1  1 when f = 8'hFF
- c_out  out  1  carry-out, active-high
- overflow  out  1  two's-complement overflow
- p  out  1  group propagate
- g  out  1  group generate

## Operation
Intermediate terms, computed bitwise from a, b and s:
- X = a | (b & {8{s0}}) | (~b & {8{s1}})
- Y = (a & ~b & {8{s2}}) | (a & b & {8{s3}})

Arithmetic mode (m=0):
- {c_out, f} = X + Y + c_in, as a 9-bit sum.
- overflow = (X[7] == Y[7]) && (f[7] != X[7]).
- Resulting functions: 1001 A+B+Cin, 0110 A−B−1+Cin, 0000 A+Cin, 0011 FF+Cin, 1111 A−1+Cin, 1100 A+A+Cin. The remaining codes follow the 74181 active-high table.

Logic mode (m=1):
- f = ~(X ^ Y). This gives 0000 ~A, 0001 ~(A|B), 0011 00, 0110 A^B, 1001 ~(A^B), 1010 B, 1011 A&B, 1100 FF, 1110 A|B, 1111 A, 1000 ~A|B.
- c_out = 0 and overflow = 0; c_in is ignored.

Mode-independent outputs:
- p = &(X ^ Y).
- g = bit 8 of (X + Y), i.e. carry generated with c_in = 0. In arithmetic mode c_out = g | (p & c_in).
- a_eq_b = (f == 8'hFF). With s=0110, m=0 and c_in=0 this flags A==B; with s=1001, m=1 it also flags equality.

## Timing
- Combinational core feeds one output register stage. All outputs are registered.
- Latency is 1 cycle: inputs sampled at rising edge k appear on the outputs after edge k.
- No handshake; a new operation can be issued every cycle.
- Reset asserted clears f, a_eq_b, c_out, overflow, p and g to 0 immediately, regardless of clk. The outputs stay 0 while rst is high.
- The first valid result appears after the first rising edge following reset deassertion.
- Wrap-around is modulo 256; the ninth bit goes only to c_out.

## Structure
- Shared package `ula_pkg` holds:
  - function-code constants (ULA_ADD=4'b1001, ULA_SUB=4'b0110, ULA_XOR=4'b0110, ULA_XNOR=4'b1001, ULA_AND=4'b1011, ULA_OR=4'b1110)
  - mode constants MODE_ARITH=0, MODE_LOGIC=1
- One combinational sub-module, `ula_8bit_core`, computes X, Y, f, flags, p and g.
- The top level instantiates `ula_8bit_core` and adds the output register.

## Test plan
- Reset: rst=1 mid-operation → all outputs 0 without a clock edge. Release rst, apply m=0, s=1001, a=05, b=03, c_in=0 → one cycle later f=08, c_out=0, overflow=0.
- Add boundaries, m=0, s=1001, c_in=0:
  - 7F+01 → f=80, overflow=1, c_out=0
  - 80+7F → f=FF, overflow=0, c_out=0, a_eq_b=1
  - FF+01 → f=00, c_out=1, overflow=0, p=0, g=1
- Subtract, m=0, s=0110, c_in=1:
  - 0A−05 → f=05, c_out=1
  - 00−01 → f=FF, c_out=0
  - 80−01 → f=7F, c_out=1, overflow=1
- Logic, m=1, a=AA, b=55:
  - s=1011 → f=00
  - s=1110 → f=FF
  - s=0110 → f=FF
  - s=1000 → f=55
  - c_out=0 and overflow=0 throughout, including with c_in=1
- Equality, m=1, s=1001:
  - a=b=55 → f=FF, a_eq_b=1
  - a=55, b=AA → f=00, a_eq_b=0
- Lookahead, m=0, s=1001, c_in=0:
  - a=0F, b=F0 → f=FF, p=1, g=0, c_out=0
  - Same inputs with c_in=1 → f=00, c_out=1
  - Back-to-back operations on consecutive cycles each emerge exactly one cycle later.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared constants for the 8-bit 74181-style ALU: function-select codes and mode values.
package ula_pkg;

    localparam int unsigned ULA_WIDTH = 8;

    // Arithmetic (m=0) and logic (m=1) views of the same select codes
    localparam logic [3:0] ULA_ADD  = 4'b1001;
    localparam logic [3:0] ULA_SUB  = 4'b0110;
    localparam logic [3:0] ULA_XOR  = 4'b0110;
    localparam logic [3:0] ULA_XNOR = 4'b1001;
    localparam logic [3:0] ULA_AND  = 4'b1011;
    localparam logic [3:0] ULA_OR   = 4'b1110;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/ula_8bit_core.sv
// Combinational core of the ALU: builds the X/Y terms, then the result, flags and group P/G.
module ula_8bit_core
    import ula_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       overflow,
    output logic       p,
    output logic       g
);

    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] xy_sum;
    logic [8:0] sum;

    always_comb begin
        x = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        y = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});

        // g is the carry of X+Y alone; c_in can only ripple out when X+Y is all ones.
        {g, xy_sum} = {1'b0, x} + {1'b0, y};
        sum = {1'b0, xy_sum} + {8'b0, c_in};
        p   = &(x ^ y);

        if (m == MODE_LOGIC) begin
            f        = ~(x ^ y);
            c_out    = 1'b0;
            overflow = 1'b0;
        end else begin
            f        = sum[7:0];
            c_out    = g | sum[8];
            overflow = (x[7] == y[7]) && (sum[7] != x[7]);
        end

        a_eq_b = (f == 8'hFF);
    end

endmodule

// File: rtl/ula_8bit.sv
// 8-bit ALU top: combinational core followed by a single output register stage.
module ula_8bit
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       overflow,
    output logic       p,
    output logic       g
);

    logic [7:0] core_f;
    logic       core_a_eq_b;
    logic       core_c_out;
    logic       core_overflow;
    logic       core_p;
    logic       core_g;

    ula_8bit_core u_core (
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .c_in     (c_in),
        .f        (core_f),
        .a_eq_b   (core_a_eq_b),
        .c_out    (core_c_out),
        .overflow (core_overflow),
        .p        (core_p),
        .g        (core_g)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f        <= '0;
            a_eq_b   <= 1'b0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            p        <= 1'b0;
            g        <= 1'b0;
        end else begin
            f        <= core_f;
            a_eq_b   <= core_a_eq_b;
            c_out    <= core_c_out;
            overflow <= core_overflow;
            p        <= core_p;
            g        <= core_g;
        end
    end

endmodule

// File: tb/tb_ula_8bit.sv
// Scoreboard bench for ula_8bit: expectations queued at issue, compared one cycle later.
module tb_ula_8bit;

    typedef struct {
        logic [7:0] f;
        logic       eq;
        logic       co;
        logic       ov;
        logic       p;
        logic       g;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] s = '0;
    logic       m = 1'b0;
    logic       c_in = 1'b0;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;
    logic       overflow;
    logic       p;
    logic       g;

    logic       drv_valid = 1'b0;
    logic       mon_v;
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;

    ula_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .c_in     (c_in),
        .f        (f),
        .a_eq_b   (a_eq_b),
        .c_out    (c_out),
        .overflow (overflow),
        .p        (p),
        .g        (g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model written straight from the X/Y definitions of the function table
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic [3:0] ms, input logic mm, input logic mc);
        exp_t       e;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] full;
        logic [8:0] gen;
        x    = ma | (mb & {8{ms[0]}}) | (~mb & {8{ms[1]}});
        y    = (ma & ~mb & {8{ms[2]}}) | (ma & mb & {8{ms[3]}});
        full = 9'(x) + 9'(y) + 9'(mc);
        gen  = 9'(x) + 9'(y);
        e.p  = &(x ^ y);
        e.g  = gen[8];
        if (mm) begin
            e.f  = ~(x ^ y);
            e.co = 1'b0;
            e.ov = 1'b0;
        end else begin
            e.f  = full[7:0];
            e.co = full[8];
            e.ov = (x[7] == y[7]) && (full[7] != x[7]);
        end
        e.eq = (e.f == 8'hFF);
        return e;
    endfunction

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] is,
                         input logic im, input logic ic, input exp_t e);
        @(negedge clk);
        a = ia;
        b = ib;
        s = is;
        m = im;
        c_in = ic;
        drv_valid = 1'b1;
        sb.push_back(e);
    endtask

    // Directed op with hand-derived expected outputs
    task automatic run(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] is,
                       input logic im, input logic ic, input logic [7:0] ef, input logic eeq,
                       input logic eco, input logic eov, input logic ep, input logic eg);
        exp_t e;
        e.f = ef; e.eq = eeq; e.co = eco; e.ov = eov; e.p = ep; e.g = eg;
        issue(ia, ib, is, im, ic, e);
    endtask

    task automatic idle();
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_f"}, 32'(f), 32'h0);
        check({tag, "_eq"}, 32'(a_eq_b), 32'h0);
        check({tag, "_co"}, 32'(c_out), 32'h0);
        check({tag, "_ov"}, 32'(overflow), 32'h0);
        check({tag, "_p"}, 32'(p), 32'h0);
        check({tag, "_g"}, 32'(g), 32'h0);
    endtask

    always @(posedge clk) begin
        mon_v = drv_valid;
        #1;
        if (mon_v && !rst) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("f", 32'(f), 32'(e.f));
                check("a_eq_b", 32'(a_eq_b), 32'(e.eq));
                check("c_out", 32'(c_out), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("p", 32'(p), 32'(e.p));
                check("g", 32'(g), 32'(e.g));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Load a non-zero result, then assert reset between clock edges
        run(8'h0F, 8'hF0, 4'b1001, 1'b0, 1'b0, 8'hFF, 1, 0, 0, 1, 0);
        idle();
        @(posedge clk);
        #3;
        check("pre_rst_f", 32'(f), 32'hFF);
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #2;
        check_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back directed ops
        run(8'h05, 8'h03, 4'b1001, 1'b0, 1'b0, 8'h08, 0, 0, 0, 0, 0);
        run(8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h80, 0, 0, 1, 0, 0);
        run(8'h80, 8'h7F, 4'b1001, 1'b0, 1'b0, 8'hFF, 1, 0, 0, 1, 0);
        run(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h00, 0, 1, 0, 0, 1);
        run(8'h0A, 8'h05, 4'b0110, 1'b0, 1'b1, 8'h05, 0, 1, 0, 0, 1);
        run(8'h00, 8'h01, 4'b0110, 1'b0, 1'b1, 8'hFF, 1, 0, 0, 0, 0);
        run(8'h80, 8'h01, 4'b0110, 1'b0, 1'b1, 8'h7F, 0, 1, 1, 0, 1);
        run(8'hAA, 8'h55, 4'b1011, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1, 0);
        run(8'hAA, 8'h55, 4'b1110, 1'b1, 1'b1, 8'hFF, 1, 0, 0, 0, 1);
        run(8'hAA, 8'h55, 4'b0110, 1'b1, 1'b1, 8'hFF, 1, 0, 0, 0, 1);
        run(8'hAA, 8'h55, 4'b1000, 1'b1, 1'b0, 8'h55, 0, 0, 0, 0, 0);
        run(8'h55, 8'h55, 4'b1001, 1'b1, 1'b0, 8'hFF, 1, 0, 0, 0, 0);
        run(8'h55, 8'hAA, 4'b1001, 1'b1, 1'b0, 8'h00, 0, 0, 0, 1, 0);
        run(8'h0F, 8'hF0, 4'b1001, 1'b0, 1'b0, 8'hFF, 1, 0, 0, 1, 0);
        run(8'h0F, 8'hF0, 4'b1001, 1'b0, 1'b1, 8'h00, 0, 1, 0, 1, 0);

        // Random ops across every select code and both modes
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] rs;
            logic       rm;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 4'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            issue(ra, rb, rs, rm, rc, model(ra, rb, rs, rm, rc));
        end
        idle();

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
